// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-port SDR SDRAM controller.
// Power-up init, single-word access with auto-precharge, strobe-driven refresh.
module sdram_ctrl #(
  parameter int INIT_WAIT = 5600,
  parameter int TRCD      = 2,
  parameter int CL        = 2,
  parameter int TRP       = 2,
  parameter int TWR       = 2,
  parameter int TRFC      = 7
) (
  input  logic        clock,
  input  logic        reset,
  output logic        ready,
  input  logic        refresh,
  input  logic        write,
  input  logic        read,
  input  logic [15:0] portD,
  output logic [15:0] portQ,
  input  logic [23:0] portA,
  output logic        ramCk,
  output logic        ramCe,
  output logic        ramCs,
  output logic        ramRas,
  output logic        ramCas,
  output logic        ramWe,
  output logic [1:0]  ramDqm,
  inout  wire  [15:0] ramDQ,
  output logic [1:0]  ramBA,
  output logic [12:0] ramA
);

  localparam int CW = $clog2(INIT_WAIT + TRFC + 16);

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  // burst length 1, sequential, CAS latency in A[6:4]
  localparam logic [12:0] MODE_A = {6'b000000, 3'(CL), 4'b0000};

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_REF1,
    S_INIT_REF2,
    S_INIT_MODE,
    S_IDLE,
    S_ACT,
    S_RW,
    S_REF
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]  cmd, cmd_n;
  logic [1:0]  ba, ba_n;
  logic [12:0] a, a_n;
  logic        dq_oe, dq_oe_n;
  logic [15:0] dq_out, dq_out_n;

  logic        rd_s, wr_s, rf_s;
  logic        rd_pend, wr_pend, rf_pend;
  logic [23:0] rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic        acc_rd;
  logic [8:0]  acc_col;
  logic [15:0] acc_data;
  logic        take_rd, take_wr, take_rf, cap;

  logic rd_edge, wr_edge, rf_edge;

  assign rd_edge = rd_s & ~read;
  assign wr_edge = wr_s & ~write;
  assign rf_edge = rf_s & ~refresh;

  assign {ramCs, ramRas, ramCas, ramWe} = cmd;
  assign ramBA  = ba;
  assign ramA   = a;
  assign ramCk  = ~clock;
  assign ramCe  = 1'b1;
  assign ramDqm = 2'b00;
  assign ramDQ  = dq_oe ? dq_out : 16'bz;

  // sequencer: next state, next command and pin values
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    cmd_n    = C_NOP;
    ba_n     = ba;
    a_n      = a;
    dq_oe_n  = 1'b0;
    dq_out_n = dq_out;
    take_rd  = 1'b0;
    take_wr  = 1'b0;
    take_rf  = 1'b0;
    cap      = 1'b0;
    unique case (state)
      S_INIT_WAIT: begin
        if (cnt == CW'(INIT_WAIT - 1)) begin
          state_n = S_INIT_PRE;
          cnt_n   = '0;
          cmd_n   = C_PRE;
          a_n     = 13'h0400;
        end
      end
      S_INIT_PRE: begin
        if (cnt == CW'(TRP)) begin
          state_n = S_INIT_REF1;
          cnt_n   = '0;
          cmd_n   = C_REF;
        end
      end
      S_INIT_REF1: begin
        if (cnt == CW'(TRFC)) begin
          state_n = S_INIT_REF2;
          cnt_n   = '0;
          cmd_n   = C_REF;
        end
      end
      S_INIT_REF2: begin
        if (cnt == CW'(TRFC)) begin
          state_n = S_INIT_MODE;
          cnt_n   = '0;
          cmd_n   = C_LMR;
          ba_n    = 2'b00;
          a_n     = MODE_A;
        end
      end
      S_INIT_MODE: begin
        if (cnt == CW'(2)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      S_IDLE: begin
        cnt_n = '0;
        if (rd_pend) begin
          take_rd = 1'b1;
          state_n = S_ACT;
          cmd_n   = C_ACT;
          ba_n    = rd_addr[23:22];
          a_n     = rd_addr[21:9];
        end else if (wr_pend) begin
          take_wr = 1'b1;
          state_n = S_ACT;
          cmd_n   = C_ACT;
          ba_n    = wr_addr[23:22];
          a_n     = wr_addr[21:9];
        end else if (rf_pend) begin
          take_rf = 1'b1;
          state_n = S_REF;
          cmd_n   = C_REF;
        end
      end
      S_ACT: begin
        if (cnt == CW'(TRCD - 1)) begin
          state_n  = S_RW;
          cnt_n    = '0;
          cmd_n    = acc_rd ? C_RD : C_WR;
          a_n      = {2'b00, 1'b1, 1'b0, acc_col};
          dq_oe_n  = ~acc_rd;
          dq_out_n = acc_data;
        end
      end
      S_RW: begin
        if (acc_rd && cnt == CW'(CL)) cap = 1'b1;
        if ((acc_rd && cnt == CW'(CL + TRP)) ||
            (!acc_rd && cnt == CW'(TWR + TRP))) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      S_REF: begin
        if (cnt == CW'(TRFC)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_INIT_WAIT;
        cnt_n   = '0;
      end
    endcase
  end

  // sequencer registers and registered SDRAM pins
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= S_INIT_WAIT;
      cnt    <= '0;
      cmd    <= C_NOP;
      ba     <= 2'b00;
      a      <= 13'h0000;
      dq_oe  <= 1'b0;
      dq_out <= 16'h0000;
      ready  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cmd    <= cmd_n;
      ba     <= ba_n;
      a      <= a_n;
      dq_oe  <= dq_oe_n;
      dq_out <= dq_out_n;
      ready  <= ready | (state_n == S_IDLE);
    end
  end

  // strobe sampling, one-deep pending requests and access latch
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_s     <= 1'b1;
      wr_s     <= 1'b1;
      rf_s     <= 1'b1;
      rd_pend  <= 1'b0;
      wr_pend  <= 1'b0;
      rf_pend  <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      acc_rd   <= 1'b0;
      acc_col  <= '0;
      acc_data <= '0;
    end else begin
      rd_s <= read;
      wr_s <= write;
      rf_s <= refresh;
      if (take_rd) rf_pend <= rf_pend;
      if (take_rd) rd_pend <= 1'b0;
      if (take_wr) wr_pend <= 1'b0;
      if (take_rf) rf_pend <= 1'b0;
      if (rd_edge && ready && (!rd_pend || take_rd)) begin
        rd_pend <= 1'b1;
        rd_addr <= portA;
      end
      if (wr_edge && ready && (!wr_pend || take_wr)) begin
        wr_pend <= 1'b1;
        wr_addr <= portA;
        wr_data <= portD;
      end
      if (rf_edge && ready && (!rf_pend || take_rf)) rf_pend <= 1'b1;
      if (take_rd) begin
        acc_rd  <= 1'b1;
        acc_col <= rd_addr[8:0];
      end
      if (take_wr) begin
        acc_rd   <= 1'b0;
        acc_col  <= wr_addr[8:0];
        acc_data <= wr_data;
      end
    end
  end

  // read data capture, CL cycles after the READ command
  always_ff @(posedge clock) begin
    if (!reset) portQ <= 16'h0000;
    else if (cap) portQ <= ramDQ;
  end

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: command scoreboard with a behavioural SDRAM model.
// Table-driven accesses plus init, held-strobe, refresh and reset sequences.
module tb_sdram_ctrl;

  localparam int IW = 20;
  localparam int CL = 2;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        refresh = 1'b1;
  logic        write = 1'b1;
  logic        read = 1'b1;
  logic [15:0] portD = '0;
  logic [23:0] portA = '0;
  logic        ready;
  logic [15:0] portQ;
  logic        ramCk, ramCe, ramCs, ramRas, ramCas, ramWe;
  logic [1:0]  ramDqm, ramBA;
  logic [12:0] ramA;
  wire  [15:0] ramDQ;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_dq = '0;

  assign ramDQ = tb_oe ? tb_dq : 16'bz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (ramDQ[g]);
  end

  sdram_ctrl #(.INIT_WAIT(IW)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .refresh(refresh), .write(write), .read(read),
    .portD(portD), .portQ(portQ), .portA(portA),
    .ramCk(ramCk), .ramCe(ramCe), .ramCs(ramCs),
    .ramRas(ramRas), .ramCas(ramCas), .ramWe(ramWe),
    .ramDqm(ramDqm), .ramDQ(ramDQ), .ramBA(ramBA), .ramA(ramA)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic [3:0]  cmd;
    logic        chk_ba;
    logic [1:0]  ba;
    logic [12:0] amask;
    logic [12:0] a;
    logic        chk_dq;
    logic [15:0] dq;
  } exp_t;

  typedef struct {
    logic        rd;
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [12:0] cola;
    logic [15:0] q;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t        exq[$];
  logic [15:0] rdq[$];
  logic [15:0] mem[logic [23:0]];
  logic [12:0] open_row[4];

  int last_act = 0, last_pre = 0, last_ref = 0, prev_ref = 0, last_lmr = 0;
  int drv_cyc = 0, q_cyc = 0;
  logic drv_on = 1'b0, q_on = 1'b0, z_chk = 1'b0;
  logic [15:0] drv_data = '0;
  logic [3:0]  mc;
  logic [23:0] key;
  exp_t        e;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic flag_fail(input string nm, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %h required none", nm, act);
  endtask

  task automatic push(input logic [3:0] c, input logic cb,
                      input logic [1:0] b, input logic [12:0] m,
                      input logic [12:0] ad, input logic cd,
                      input logic [15:0] d);
    exp_t x;
    x.cmd = c; x.chk_ba = cb; x.ba = b; x.amask = m;
    x.a = ad; x.chk_dq = cd; x.dq = d;
    exq.push_back(x);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // pin monitor, SDRAM model and scoreboard
  initial forever begin
    @(negedge clock);
    if (z_chk) begin
      z_chk = 1'b0;
      chk("dq_release", {16'h0, ramDQ}, 32'h0000FFFF);
    end
    if (q_on && cyc == q_cyc) begin
      q_on = 1'b0;
      if (rdq.size() == 0) flag_fail("unexpected_read_data", {16'h0, portQ});
      else chk("portQ", {16'h0, portQ}, {16'h0, rdq.pop_front()});
    end
    if (tb_oe && cyc == drv_cyc + 1) tb_oe = 1'b0;
    if (drv_on && cyc == drv_cyc) begin
      tb_oe = 1'b1;
      tb_dq = drv_data;
      drv_on = 1'b0;
    end
    mc = {ramCs, ramRas, ramCas, ramWe};
    if (mc !== C_NOP) begin
      if (exq.size() == 0) begin
        flag_fail("unexpected_cmd", {28'h0, mc});
      end else begin
        e = exq.pop_front();
        chk("cmd", {28'h0, mc}, {28'h0, e.cmd});
        if (e.chk_ba) chk("ba", {30'h0, ramBA}, {30'h0, e.ba});
        if (e.amask != 13'h0)
          chk("addr", {19'h0, ramA & e.amask}, {19'h0, e.a & e.amask});
        if (e.chk_dq) chk("wdata", {16'h0, ramDQ}, {16'h0, e.dq});
      end
      case (mc)
        C_ACT: begin
          open_row[ramBA] = ramA;
          last_act = cyc;
        end
        C_RD: begin
          chk("trcd_rd", cyc - last_act, 2);
          key = {ramBA, open_row[ramBA], ramA[8:0]};
          drv_data = mem.exists(key) ? mem[key] : (key[15:0] ^ 16'h5A5A);
          drv_cyc = cyc + CL;
          drv_on = 1'b1;
          q_cyc = cyc + CL + 1;
          q_on = 1'b1;
        end
        C_WR: begin
          chk("trcd_wr", cyc - last_act, 2);
          key = {ramBA, open_row[ramBA], ramA[8:0]};
          mem[key] = ramDQ;
          z_chk = 1'b1;
        end
        C_REF: begin
          prev_ref = last_ref;
          last_ref = cyc;
        end
        C_LMR: last_lmr = cyc;
        C_PRE: last_pre = cyc;
        default: ;
      endcase
    end
  end

  task automatic strobe(input int kind, input logic [23:0] ad,
                        input logic [15:0] d, input int hold);
    @(negedge clock);
    portA = ad;
    portD = d;
    if (kind == 0) read = 1'b0;
    if (kind == 1 || kind == 3) write = 1'b0;
    if (kind == 2 || kind == 3) refresh = 1'b0;
    repeat (hold) @(negedge clock);
    read = 1'b1;
    write = 1'b1;
    refresh = 1'b1;
  endtask

  task automatic init_run();
    int rc;
    push(C_PRE, 1'b0, 2'b00, 13'h0400, 13'h0400, 1'b0, 16'h0);
    push(C_REF, 1'b0, 2'b00, 13'h0000, 13'h0000, 1'b0, 16'h0);
    push(C_REF, 1'b0, 2'b00, 13'h0000, 13'h0000, 1'b0, 16'h0);
    push(C_LMR, 1'b1, 2'b00, 13'h1FFF, 13'h0020, 1'b0, 16'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) strobe(0, 24'h000123, 16'h0, 2);
    rc = -1;
    for (int i = 0; i < 300 && rc < 0; i++) begin
      @(negedge clock);
      if (ready === 1'b1) rc = cyc;
    end
    if (rc < 0) begin
      flag_fail("ready_timeout", {31'h0, ready});
    end else begin
      chk("pre_to_ref", prev_ref - last_pre, 3);
      chk("ref_to_ref", last_ref - prev_ref, 8);
      chk("ref_to_lmr", last_lmr - last_ref, 8);
      chk("lmr_to_ready", rc - last_lmr, 3);
    end
    chk("init_drain", exq.size(), 0);
  endtask

  vec_t vecs[8];
  int found;

  initial begin
    vecs[0] = '{1'b0, 24'h412345, 16'hA55A, 2'd1, 13'h0091, 13'h0545, 16'h0};
    vecs[1] = '{1'b1, 24'h412345, 16'h0,    2'd1, 13'h0091, 13'h0545, 16'hA55A};
    vecs[2] = '{1'b1, 24'h000000, 16'h0,    2'd0, 13'h0000, 13'h0400, 16'h5A5A};
    vecs[3] = '{1'b1, 24'hFFFFFF, 16'h0,    2'd3, 13'h1FFF, 13'h05FF, 16'hA5A5};
    vecs[4] = '{1'b0, 24'h0001FF, 16'h3C3C, 2'd0, 13'h0000, 13'h05FF, 16'h0};
    vecs[5] = '{1'b1, 24'h0001FF, 16'h0,    2'd0, 13'h0000, 13'h05FF, 16'h3C3C};
    vecs[6] = '{1'b0, 24'hC00200, 16'h0F0F, 2'd3, 13'h0001, 13'h0400, 16'h0};
    vecs[7] = '{1'b1, 24'hC00200, 16'h0,    2'd3, 13'h0001, 13'h0400, 16'h0F0F};

    repeat (3) @(negedge clock);
    chk("rst_ready", {31'h0, ready}, 0);
    chk("rst_portQ", {16'h0, portQ}, 0);
    chk("rst_cmd", {28'h0, ramCs, ramRas, ramCas, ramWe}, {28'h0, C_NOP});
    chk("rst_dq", {16'h0, ramDQ}, 32'h0000FFFF);
    chk("cke", {31'h0, ramCe}, 1);
    chk("dqm", {30'h0, ramDqm}, 0);
    chk("ramck", {31'h0, ramCk}, 1);

    init_run();

    for (int i = 0; i < 8; i++) begin
      push(C_ACT, 1'b1, vecs[i].ba, 13'h1FFF, vecs[i].row, 1'b0, 16'h0);
      push(vecs[i].rd ? C_RD : C_WR, 1'b1, vecs[i].ba, 13'h1FFF,
           vecs[i].cola, ~vecs[i].rd, vecs[i].data);
      if (vecs[i].rd) rdq.push_back(vecs[i].q);
      strobe(vecs[i].rd ? 0 : 1, vecs[i].addr, vecs[i].data, 2);
      repeat (14) @(negedge clock);
      chk("vec_cmd_drain", exq.size(), 0);
      chk("vec_rd_drain", rdq.size(), 0);
    end

    push(C_ACT, 1'b1, 2'd1, 13'h1FFF, 13'h0091, 1'b0, 16'h0);
    push(C_RD, 1'b1, 2'd1, 13'h1FFF, 13'h0545, 1'b0, 16'h0);
    rdq.push_back(16'hA55A);
    strobe(0, 24'h412345, 16'h0, 50);
    repeat (10) @(negedge clock);
    chk("hold_cmd_drain", exq.size(), 0);
    chk("hold_rd_drain", rdq.size(), 0);

    push(C_ACT, 1'b1, 2'd0, 13'h1FFF, 13'h0000, 1'b0, 16'h0);
    push(C_WR, 1'b1, 2'd0, 13'h1FFF, 13'h0410, 1'b1, 16'h7777);
    push(C_REF, 1'b0, 2'd0, 13'h0000, 13'h0000, 1'b0, 16'h0);
    strobe(3, 24'h000010, 16'h7777, 2);
    repeat (25) @(negedge clock);
    chk("wr_ref_drain", exq.size(), 0);
    chk("act_to_ref", last_ref - last_act, 8);

    push(C_ACT, 1'b1, 2'd0, 13'h1FFF, 13'h0000, 1'b0, 16'h0);
    push(C_RD, 1'b1, 2'd0, 13'h1FFF, 13'h0410, 1'b0, 16'h0);
    rdq.push_back(16'h7777);
    strobe(0, 24'h000010, 16'h0, 2);
    repeat (14) @(negedge clock);
    chk("after_ref_drain", rdq.size(), 0);

    push(C_ACT, 1'b1, 2'd1, 13'h1FFF, 13'h0091, 1'b0, 16'h0);
    push(C_WR, 1'b1, 2'd1, 13'h1FFF, 13'h0545, 1'b1, 16'h1111);
    strobe(1, 24'h412345, 16'h1111, 2);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clock);
      if ({ramCs, ramRas, ramCas, ramWe} === C_WR) found = 1;
    end
    if (found == 0) flag_fail("write_timeout", 0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_dq", {16'h0, ramDQ}, 32'h0000FFFF);
    chk("mid_rst_ready", {31'h0, ready}, 0);
    chk("mid_rst_cmd", {28'h0, ramCs, ramRas, ramCas, ramWe}, {28'h0, C_NOP});
    chk("mid_rst_portQ", {16'h0, portQ}, 0);
    chk("mid_rst_drain", exq.size(), 0);
    @(negedge clock);
    init_run();

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
